// File: rtl/ms_tmr32_in_cond.sv
// Input conditioner for the ms_tmr32 counter/capture pin: synchroniser, polarity
// select, run-length glitch filter, edge strobes and a saturating glitch counter.
module ms_tmr32_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FLT_W       = 8,
  parameter int GCNT_W      = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              pin_in,
  input  logic              en,
  input  logic              inv,
  input  logic [FLT_W-1:0]  flt_len,
  input  logic              glitch_clr,
  output logic              ctr_out,
  output logic              rise_p,
  output logic              fall_p,
  output logic [GCNT_W-1:0] glitch_cnt
);

  logic [SYNC_STAGES-1:0] sync;
  logic [FLT_W-1:0]       cnt;
  logic                   ctr_q;
  logic                   x;
  logic                   match;
  logic                   glitch;

  // Synchroniser runs even when disabled so the level is settled when en rises.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], pin_in};
  end

  assign x      = sync[SYNC_STAGES-1] ^ inv;
  assign match  = (x == ctr_out);
  // A run that ends before acceptance is a rejected pulse.
  assign glitch = en && match && (cnt != '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctr_out <= 1'b0;
      ctr_q   <= 1'b0;
      cnt     <= '0;
    end else if (!en) begin
      ctr_out <= 1'b0;
      ctr_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      ctr_q <= ctr_out;
      if (match) begin
        cnt <= '0;
      end else if (cnt >= flt_len) begin
        // >= so a shortened flt_len takes effect at once instead of stalling.
        ctr_out <= x;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                   glitch_cnt <= '0;
    else if (glitch_clr)            glitch_cnt <= '0;
    else if (glitch && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + 1'b1;
  end

  assign rise_p = ctr_out & ~ctr_q;
  assign fall_p = ~ctr_out & ctr_q;

endmodule

// File: tb/tb_ms_tmr32_in_cond.sv
// Scoreboarded bench for ms_tmr32_in_cond: directed scenarios followed by random
// pin/control traffic, all compared cycle by cycle against a behavioural model.
module tb_ms_tmr32_in_cond;
  localparam int SYNC  = 2;
  localparam int FLT_W = 8;
  localparam int GW    = 8;
  localparam int GMAX  = (1 << GW) - 1;

  logic             PCLK = 1'b0;
  logic             PRESETn = 1'b0;
  logic             pin_in = 1'b0, en = 1'b0, inv = 1'b0, glitch_clr = 1'b0;
  logic [FLT_W-1:0] flt_len = '0;
  logic             ctr_out, rise_p, fall_p;
  logic [GW-1:0]    glitch_cnt;

  ms_tmr32_in_cond #(.SYNC_STAGES(SYNC), .FLT_W(FLT_W), .GCNT_W(GW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .pin_in(pin_in), .en(en), .inv(inv),
    .flt_len(flt_len), .glitch_clr(glitch_clr), .ctr_out(ctr_out),
    .rise_p(rise_p), .fall_p(fall_p), .glitch_cnt(glitch_cnt)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { int lvl; int rise; int fall; int gcnt; } exp_t;
  exp_t exp_q[$];
  int   total = 0, bad = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: pin samples delayed SYNC cycles, level accepted once the
  // differing value has been seen for more than flt_len consecutive cycles.
  int pin_hist[$];
  int m_lvl, m_seen, m_gcnt;
  initial begin
    for (int i = 0; i < SYNC; i++) pin_hist.push_back(0);
    m_lvl = 0; m_seen = 0; m_gcnt = 0;
  end

  always @(negedge PRESETn) begin
    pin_hist.delete();
    for (int i = 0; i < SYNC; i++) pin_hist.push_back(0);
    m_lvl = 0; m_seen = 0; m_gcnt = 0;
    exp_q.delete();
  end

  always @(posedge PCLK) begin
    exp_t e;
    int   seen_val, old_lvl, rejected;
    if (!PRESETn) begin
      e = '{0, 0, 0, 0};
    end else begin
      seen_val = pin_hist[0] ^ int'(inv);
      pin_hist.push_back(int'(pin_in));
      void'(pin_hist.pop_front());
      old_lvl  = m_lvl;
      rejected = 0;
      if (!en) begin
        m_lvl = 0; m_seen = 0;
      end else if (seen_val == m_lvl) begin
        rejected = (m_seen > 0);
        m_seen = 0;
      end else if (m_seen >= int'(flt_len)) begin
        m_lvl = seen_val; m_seen = 0;
      end else begin
        m_seen++;
      end
      if (glitch_clr)                   m_gcnt = 0;
      else if (rejected && m_gcnt < GMAX) m_gcnt++;
      e.lvl  = m_lvl;
      e.rise = (en && old_lvl == 0 && m_lvl == 1);
      e.fall = (en && old_lvl == 1 && m_lvl == 0);
      e.gcnt = m_gcnt;
    end
    exp_q.push_back(e);
  end

  // Monitor: one expected record per edge, checked mid-cycle.
  always @(negedge PCLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctr_out", int'(ctr_out), e.lvl);
      chk("rise_p", int'(rise_p), e.rise);
      chk("fall_p", int'(fall_p), e.fall);
      chk("glitch_cnt", int'(glitch_cnt), e.gcnt);
      if (rise_p && fall_p) chk("strobe_excl", 1, 0);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge PCLK);
  endtask

  initial begin
    cyc(3);
    PRESETn = 1'b1;
    en = 1'b1; flt_len = 8'd3;
    cyc(12);

    // Latency 0->1 and 1->0 at SYNC + flt_len + 1 = 6 edges.
    pin_in = 1'b1;
    cyc(5); chk("lat_rise_early", int'(ctr_out), 0);
    cyc(1); chk("lat_rise_lvl", int'(ctr_out), 1); chk("lat_rise_p", int'(rise_p), 1);
    cyc(1); chk("lat_rise_once", int'(rise_p), 0);
    pin_in = 1'b0;
    cyc(5); chk("lat_fall_early", int'(ctr_out), 1);
    cyc(1); chk("lat_fall_p", int'(fall_p), 1);
    cyc(4);

    // Glitch reject then a just-long-enough pulse.
    glitch_clr = 1'b1; cyc(1); glitch_clr = 1'b0;
    pin_in = 1'b1; cyc(2); pin_in = 1'b0; cyc(8);
    chk("glitch2_lvl", int'(ctr_out), 0); chk("glitch2_cnt", int'(glitch_cnt), 1);
    pin_in = 1'b1; cyc(4); pin_in = 1'b0; cyc(12);
    chk("pulse4_cnt", int'(glitch_cnt), 1);

    // Saturation, then clear colliding with a rejection.
    for (int i = 0; i < 300; i++) begin pin_in = 1'b1; cyc(1); pin_in = 1'b0; cyc(1); end
    cyc(4); chk("sat_cnt", int'(glitch_cnt), GMAX);
    pin_in = 1'b1; cyc(1); pin_in = 1'b0; cyc(SYNC);
    glitch_clr = 1'b1; cyc(1); glitch_clr = 1'b0;
    chk("clr_prio", int'(glitch_cnt), 0);
    cyc(4);

    // flt_len = 0 and mid-run reduction.
    flt_len = 8'd0; pin_in = 1'b1;
    cyc(2); chk("fl0_early", int'(ctr_out), 0);
    cyc(1); chk("fl0_lvl", int'(ctr_out), 1);
    cyc(3);
    flt_len = 8'd10; pin_in = 1'b0;
    cyc(7); chk("reduce_hold", int'(ctr_out), 1);
    flt_len = 8'd2;
    cyc(1); chk("reduce_accept", int'(ctr_out), 0);
    cyc(4);

    // Polarity flip and disable while high.
    flt_len = 8'd3; inv = 1'b1;
    cyc(3); chk("inv_early", int'(ctr_out), 0);
    cyc(1); chk("inv_lvl", int'(ctr_out), 1); chk("inv_rise", int'(rise_p), 1);
    cyc(2);
    en = 1'b0;
    cyc(1); chk("dis_lvl", int'(ctr_out), 0); chk("dis_nofall", int'(fall_p), 0);
    en = 1'b1; inv = 1'b0;
    cyc(8);

    // Reset mid-run with pin high, release while disabled.
    pin_in = 1'b1; cyc(3);
    #2 PRESETn = 1'b0;
    #1 chk("rst_lvl", int'(ctr_out), 0); chk("rst_gcnt", int'(glitch_cnt), 0);
    en = 1'b0;
    cyc(2); PRESETn = 1'b1;
    cyc(6); chk("rst_rel_lvl", int'(ctr_out), 0); chk("rst_rel_rise", int'(rise_p), 0);
    en = 1'b1;
    cyc(4); chk("en_rise", int'(rise_p), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) pin_in = ~pin_in;
      if ($urandom_range(0, 99) == 0) flt_len = FLT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) inv = ~inv;
      if ($urandom_range(0, 99) == 0) en = ~en;
      if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      glitch_clr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 PRESETn = 1'b0;
        cyc(1); PRESETn = 1'b1;
      end
      cyc(1);
    end
    glitch_clr = 1'b0;
    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
